// File: rtl/instance_slice_view.sv
// Loadable/incrementing state register declared [LEFT:RIGHT] with a registered
// wrap pulse and three combinational slice views (fixed, "+:", "-:").
module instance_slice_view #(
    parameter int LEFT         = 0,
    parameter int RIGHT        = 0,
    parameter int INNER_LEFT   = 0,
    parameter int INNER_RIGHT  = 0,
    parameter int INNER_OFFSET = 0,
    localparam int N = ((LEFT > RIGHT) ? (LEFT - RIGHT) : (RIGHT - LEFT)) + 1,
    localparam int K = ((INNER_LEFT > INNER_RIGHT) ?
                        (INNER_LEFT - INNER_RIGHT) :
                        (INNER_RIGHT - INNER_LEFT)) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [LEFT:RIGHT] ld_val,
    input  logic              inc,
    output logic [LEFT:RIGHT] xs,
    output logic [K-1:0]      l_xs,
    output logic [K-1:0]      m_xs,
    output logic [K-1:0]      n_xs,
    output logic              wrap
);

    localparam bit ASC  = (LEFT < RIGHT);
    localparam bit IASC = (INNER_LEFT < INNER_RIGHT);
    localparam int A    = INNER_OFFSET;

    localparam logic [N-1:0] ONE = N'(1);

    // Storage position of a declared index: 0 is the LSB (xs[RIGHT]).
    function automatic int pos_of(input int idx);
        pos_of = ASC ? (RIGHT - idx) : (idx - RIGHT);
    endfunction

    function automatic bit in_rng(input int p);
        in_rng = (p >= 0) && (p < N);
    endfunction

    localparam bit INNER_OK =
        in_rng(pos_of(INNER_LEFT)) && in_rng(pos_of(INNER_RIGHT)) &&
        ((INNER_LEFT == INNER_RIGHT) || (IASC == ASC));

    if (!INNER_OK) begin : g_bad_inner
        $error("INNER_LEFT/INNER_RIGHT outside [LEFT:RIGHT] or wrong direction");
    end

    logic [N-1:0] xs_q;
    logic [N-1:0] xs_d;
    logic         wrap_q;
    logic         wrap_d;

    always_comb begin
        xs_d   = xs_q;
        wrap_d = 1'b0;
        if (ld) begin
            xs_d = ld_val;
        end else if (inc) begin
            xs_d   = xs_q + ONE;
            wrap_d = &xs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            xs_q   <= xs_d;
            wrap_q <= wrap_d;
        end
    end

    assign xs   = xs_q;
    assign wrap = wrap_q;

    // View bit j (j=K-1 is MSB) maps to the first-named slice index stepped
    // toward the last-named one; out-of-range sources read as constant 0.
    for (genvar j = 0; j < K; j++) begin : g_view
        localparam int LI = IASC ? (INNER_LEFT + (K - 1 - j))
                                 : (INNER_LEFT - (K - 1 - j));
        localparam int MI = ASC ? (A + (K - 1 - j)) : (A + j);
        localparam int NI = ASC ? (A - j) : (A - K + 1 + j);
        localparam int LP = pos_of(LI);
        localparam int MP = pos_of(MI);
        localparam int NP = pos_of(NI);

        if (in_rng(LP)) begin : g_l_in
            assign l_xs[j] = xs_q[LP];
        end else begin : g_l_out
            assign l_xs[j] = 1'b0;
        end

        if (in_rng(MP)) begin : g_m_in
            assign m_xs[j] = xs_q[MP];
        end else begin : g_m_out
            assign m_xs[j] = 1'b0;
        end

        if (in_rng(NP)) begin : g_n_in
            assign n_xs[j] = xs_q[NP];
        end else begin : g_n_out
            assign n_xs[j] = 1'b0;
        end
    end

endmodule

// File: tb/tb_instance_slice_view.sv
// Bench for instance_slice_view: four parameterisations on one clock,
// directed corner steps then random traffic against a value-level model.
module tb_instance_slice_view;

    localparam int PL[4]  = '{0, 3, 1, -2};
    localparam int PR[4]  = '{3, 0, 0, 1};
    localparam int PIL[4] = '{1, 2, 0, -1};
    localparam int PIR[4] = '{2, 1, 0, 0};
    localparam int PO[4]  = '{-1, 2, 1, 2};

    logic clk = 1'b0;
    logic rst_n;
    logic ld[4];
    logic inc[4];
    logic [3:0] ldv[4];

    logic [3:0] a_xs, b_xs, d_xs;
    logic [1:0] c_xs;
    logic [1:0] a_l, a_m, a_n, b_l, b_m, b_n, d_l, d_m, d_n;
    logic       c_l, c_m, c_n;
    logic       a_w, b_w, c_w, d_w;

    logic [3:0] mv[4];
    logic       mw[4];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instance_slice_view #(.LEFT(0), .RIGHT(3), .INNER_LEFT(1),
        .INNER_RIGHT(2), .INNER_OFFSET(-1)) u_a (
        .clk(clk), .rst_n(rst_n), .ld(ld[0]), .ld_val(ldv[0]),
        .inc(inc[0]), .xs(a_xs), .l_xs(a_l), .m_xs(a_m), .n_xs(a_n),
        .wrap(a_w));

    instance_slice_view #(.LEFT(3), .RIGHT(0), .INNER_LEFT(2),
        .INNER_RIGHT(1), .INNER_OFFSET(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ld(ld[1]), .ld_val(ldv[1]),
        .inc(inc[1]), .xs(b_xs), .l_xs(b_l), .m_xs(b_m), .n_xs(b_n),
        .wrap(b_w));

    instance_slice_view #(.LEFT(1), .RIGHT(0), .INNER_LEFT(0),
        .INNER_RIGHT(0), .INNER_OFFSET(1)) u_c (
        .clk(clk), .rst_n(rst_n), .ld(ld[2]), .ld_val(ldv[2][1:0]),
        .inc(inc[2]), .xs(c_xs), .l_xs(c_l), .m_xs(c_m), .n_xs(c_n),
        .wrap(c_w));

    instance_slice_view #(.LEFT(-2), .RIGHT(1), .INNER_LEFT(-1),
        .INNER_RIGHT(0), .INNER_OFFSET(2)) u_d (
        .clk(clk), .rst_n(rst_n), .ld(ld[3]), .ld_val(ldv[3]),
        .inc(inc[3]), .xs(d_xs), .l_xs(d_l), .m_xs(d_m), .n_xs(d_n),
        .wrap(d_w));

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int nbits(input int i);
        return iabs(PR[i] - PL[i]) + 1;
    endfunction

    // Reads the Verilog slice xs[first:last] of DUT i from its numeric value.
    function automatic logic [3:0] slice(input int i, input int first,
                                         input int last, input logic [3:0] v);
        logic [3:0] r;
        int k, step, idx, p;
        logic b;
        r = '0;
        k = iabs(last - first) + 1;
        step = (last > first) ? 1 : -1;
        for (int t = 0; t < k; t++) begin
            idx = first + t * step;
            p = (PL[i] < PR[i]) ? (PR[i] - idx) : (idx - PR[i]);
            b = (p >= 0 && p < nbits(i)) ? v[p] : 1'b0;
            r = {r[2:0], b};
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] o,
                       input logic [3:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic model_update();
        int mask;
        for (int i = 0; i < 4; i++) begin
            mask = (1 << nbits(i)) - 1;
            if (!rst_n) begin
                mv[i] = '0;
                mw[i] = 1'b0;
            end else if (ld[i]) begin
                mv[i] = ldv[i] & 4'(mask);
                mw[i] = 1'b0;
            end else if (inc[i]) begin
                mw[i] = (int'(mv[i]) == mask);
                mv[i] = 4'((int'(mv[i]) + 1) & mask);
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] ox[4], olv[4], omv[4], onv[4];
        logic       ow[4];
        int k, a;
        ox[0] = a_xs; ox[1] = b_xs; ox[2] = {2'b00, c_xs}; ox[3] = d_xs;
        olv[0] = {2'b00, a_l}; olv[1] = {2'b00, b_l};
        olv[2] = {3'b000, c_l}; olv[3] = {2'b00, d_l};
        omv[0] = {2'b00, a_m}; omv[1] = {2'b00, b_m};
        omv[2] = {3'b000, c_m}; omv[3] = {2'b00, d_m};
        onv[0] = {2'b00, a_n}; onv[1] = {2'b00, b_n};
        onv[2] = {3'b000, c_n}; onv[3] = {2'b00, d_n};
        ow[0] = a_w; ow[1] = b_w; ow[2] = c_w; ow[3] = d_w;
        for (int i = 0; i < 4; i++) begin
            k = iabs(PIR[i] - PIL[i]) + 1;
            a = PO[i];
            cmp($sformatf("xs%0d", i), ox[i], mv[i]);
            cmp($sformatf("wrap%0d", i), {3'b000, ow[i]}, {3'b000, mw[i]});
            cmp($sformatf("l%0d", i), olv[i], slice(i, PIL[i], PIR[i], mv[i]));
            if (PL[i] < PR[i]) begin
                cmp($sformatf("m%0d", i), omv[i], slice(i, a, a + k - 1, mv[i]));
                cmp($sformatf("n%0d", i), onv[i], slice(i, a - k + 1, a, mv[i]));
            end else begin
                cmp($sformatf("m%0d", i), omv[i], slice(i, a + k - 1, a, mv[i]));
                cmp($sformatf("n%0d", i), onv[i], slice(i, a, a - k + 1, mv[i]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            ld[i] = 1'b0;
            inc[i] = 1'b0;
            ldv[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mv[i] = '0;
            mw[i] = 1'b0;
        end
        idle();
        // Reset together with load and increment: reset must win.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld[i] = 1'b1;
            inc[i] = 1'b1;
            ldv[i] = 4'($urandom);
        end
        #1;
        tick();
        cmp("rst_ld_xs_a", a_xs, 4'b0000);
        cmp("rst_ld_wrap_a", {3'b000, a_w}, 4'b0000);
        tick();
        rst_n = 1'b1;
        idle();

        // Known-pattern views on the ascending and descending vectors.
        ld[0] = 1'b1; ldv[0] = 4'b1011;
        ld[1] = 1'b1; ldv[1] = 4'b1011;
        ld[3] = 1'b1; ldv[3] = 4'b1111;
        tick();
        idle();
        cmp("asc_l", {2'b00, a_l}, 4'b0001);
        cmp("asc_m", {2'b00, a_m}, 4'b0001);
        cmp("asc_n", {2'b00, a_n}, 4'b0000);
        cmp("desc_l", {2'b00, b_l}, 4'b0001);
        cmp("desc_m", {2'b00, b_m}, 4'b0010);
        cmp("desc_n", {2'b00, b_n}, 4'b0001);
        cmp("oor_m", {2'b00, d_m}, 4'b0000);

        // Two-bit counter runs through a full wrap.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        inc[2] = 1'b1;
        tick();
        cmp("cnt1", {2'b00, c_xs}, 4'b0001);
        tick();
        cmp("cnt2", {2'b00, c_xs}, 4'b0010);
        tick();
        cmp("cnt3", {2'b00, c_xs}, 4'b0011);
        cmp("cnt3_wrap", {3'b000, c_w}, 4'b0000);
        tick();
        cmp("cnt4", {2'b00, c_xs}, 4'b0000);
        cmp("cnt4_wrap", {3'b000, c_w}, 4'b0001);
        inc[2] = 1'b0;
        tick();
        cmp("cnt5_wrap", {3'b000, c_w}, 4'b0000);

        // Load of zero beats an increment from all-ones: no wrap.
        ld[2] = 1'b1; ldv[2] = 4'b0011;
        tick();
        ldv[2] = 4'b0000; inc[2] = 1'b1;
        tick();
        cmp("ld0_xs", {2'b00, c_xs}, 4'b0000);
        cmp("ld0_wrap", {3'b000, c_w}, 4'b0000);

        // Reset during the wrap pulse clears it on the next edge.
        ldv[2] = 4'b0011;
        tick();
        ld[2] = 1'b0;
        tick();
        cmp("wrap_pre_rst", {3'b000, c_w}, 4'b0001);
        rst_n = 1'b0;
        tick();
        cmp("wrap_post_rst", {3'b000, c_w}, 4'b0000);
        rst_n = 1'b1;
        idle();
        tick();

        for (int cyc = 0; cyc < 300; cyc++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 4; i++) begin
                ld[i] = ($urandom_range(0, 4) == 0);
                inc[i] = ($urandom_range(0, 3) != 0);
                ldv[i] = 4'($urandom);
                if (i == 2) ldv[i][3:2] = 2'b00;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
